// File: rtl/space_invaders_pkg.sv
// space_invaders_pkg: keycode constants and fire FSM state shared by the game input logic
package space_invaders_pkg;

    localparam logic [7:0] KC_SPACE = 8'd44;
    localparam logic [7:0] KC_W     = 8'd26;
    localparam logic [7:0] KC_LEFT  = 8'd80;
    localparam logic [7:0] KC_A     = 8'd4;
    localparam logic [7:0] KC_RIGHT = 8'd79;
    localparam logic [7:0] KC_D     = 8'd7;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        COOLDOWN,
        WAIT_RELEASE
    } fire_state_t;

    function automatic logic is_fire(input logic [7:0] kc);
        return (kc == KC_SPACE) || (kc == KC_W);
    endfunction

    function automatic logic is_left(input logic [7:0] kc);
        return (kc == KC_LEFT) || (kc == KC_A);
    endfunction

    function automatic logic is_right(input logic [7:0] kc);
        return (kc == KC_RIGHT) || (kc == KC_D);
    endfunction

endpackage

// File: rtl/keycode_filter.sv
// keycode_filter: passes a keycode on only after it has held steady for STABLE_CYCLES samples
module keycode_filter
    import space_invaders_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       Clk,
    input  logic       reset_h,
    input  logic [7:0] keycode,
    output logic [7:0] accepted
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

    logic [7:0]    kc_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // count consecutive matching samples, saturating once the value is trusted
    always_comb cnt_next = (keycode != kc_q) ? '0 : (cnt == CMAX) ? cnt : cnt + 1'b1;

    // sample register, stability counter and the accepted keycode
    always_ff @(posedge Clk or posedge reset_h) begin
        if (reset_h) begin
            kc_q     <= '0;
            cnt      <= '0;
            accepted <= '0;
        end else begin
            kc_q <= keycode;
            cnt  <= cnt_next;
            if (cnt_next == CMAX)
                accepted <= kc_q;
        end
    end

endmodule

// File: rtl/keycode_input_decoder.sv
// keycode_input_decoder: filters the NIOS keycode into movement levels and cooldown-limited shoot pulses
module keycode_input_decoder
    import space_invaders_pkg::*;
#(
    parameter int STABLE_CYCLES   = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter bit AUTOFIRE        = 1'b0
) (
    input  logic       Clk,
    input  logic       reset_h,
    input  logic [7:0] keycode,
    input  logic       VGA_VS,
    output logic       shoot,
    output logic       left,
    output logic       right,
    output logic       key_valid,
    output logic [7:0] shot_count
);

    localparam int CDW = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN_FRAMES);
    localparam logic [CDW-1:0] CD_LAST = CDW'(1);

    logic [7:0]     accepted;
    logic           fire_held;
    logic           vs_q;
    logic           tick;
    logic [CDW-1:0] cd_cnt;
    fire_state_t    state;
    fire_state_t    state_next;

    keycode_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .Clk     (Clk),
        .reset_h (reset_h),
        .keycode (keycode),
        .accepted(accepted)
    );

    // frame tick on each falling edge of the active-low vertical sync
    always_ff @(posedge Clk or posedge reset_h) begin
        if (reset_h)
            vs_q <= 1'b1;
        else
            vs_q <= VGA_VS;
    end

    assign tick = vs_q & ~VGA_VS;

    // registered decode of the accepted keycode into control levels
    always_ff @(posedge Clk or posedge reset_h) begin
        if (reset_h) begin
            left      <= 1'b0;
            right     <= 1'b0;
            key_valid <= 1'b0;
            fire_held <= 1'b0;
        end else begin
            left      <= is_left(accepted);
            right     <= is_right(accepted);
            key_valid <= accepted != 8'd0;
            fire_held <= is_fire(accepted);
        end
    end

    // fire FSM state register
    always_ff @(posedge Clk or posedge reset_h) begin
        if (reset_h)
            state <= IDLE;
        else
            state <= state_next;
    end

    // fire FSM transitions; the last cooldown tick decides between refire, wait and idle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:         state_next = fire_held ? FIRE : IDLE;
            FIRE:         state_next = COOLDOWN;
            COOLDOWN:     if (tick && cd_cnt == CD_LAST)
                              state_next = !fire_held ? IDLE : AUTOFIRE ? FIRE : WAIT_RELEASE;
            WAIT_RELEASE: state_next = fire_held ? WAIT_RELEASE : IDLE;
            default:      state_next = IDLE;
        endcase
    end

    // a shot lasts exactly the single FIRE cycle
    always_comb shoot = (state == FIRE);

    // cooldown frame counter and shot tally; ticks during FIRE are not counted
    always_ff @(posedge Clk or posedge reset_h) begin
        if (reset_h) begin
            cd_cnt     <= '0;
            shot_count <= '0;
        end else if (state == FIRE) begin
            cd_cnt     <= CD_LOAD;
            shot_count <= shot_count + 8'd1;
        end else if (state == COOLDOWN && tick && cd_cnt != '0) begin
            cd_cnt <= cd_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_keycode_input_decoder.sv
// tb_keycode_input_decoder: two decoder configurations checked every cycle against a behavioural model
module tb_keycode_input_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset_h;
    logic [7:0] keycode;
    logic       VGA_VS;
    logic       shoot [2];
    logic       left [2];
    logic       right [2];
    logic       key_valid [2];
    logic [7:0] shot_count [2];

    always #5 clk = ~clk;

    keycode_input_decoder #(.STABLE_CYCLES(S), .COOLDOWN_FRAMES(8), .AUTOFIRE(1'b0)) dut_a (
        .Clk(clk), .reset_h(reset_h), .keycode(keycode), .VGA_VS(VGA_VS),
        .shoot(shoot[0]), .left(left[0]), .right(right[0]), .key_valid(key_valid[0]),
        .shot_count(shot_count[0])
    );

    keycode_input_decoder #(.STABLE_CYCLES(S), .COOLDOWN_FRAMES(2), .AUTOFIRE(1'b1)) dut_b (
        .Clk(clk), .reset_h(reset_h), .keycode(keycode), .VGA_VS(VGA_VS),
        .shoot(shoot[1]), .left(left[1]), .right(right[1]), .key_valid(key_valid[1]),
        .shot_count(shot_count[1])
    );

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: acceptance from the raw sample history, shots from remaining cooldown ticks
    int       hist[$];
    int       acc_m;
    bit       left_m, right_m, kv_m, held_m, vs_m;
    bit       sh_m [2];
    int       cd_m [2];
    bit       rel_m [2];
    int       cnt_m [2];
    bit       shoot_last [2];
    int       pulses [2];
    bit       chk_coincide = 1'b0;

    function automatic int cd_frames(input int i);
        return (i == 0) ? 8 : 2;
    endfunction

    task automatic model_reset();
        hist = {};
        repeat (S + 1) hist.push_back(0);
        acc_m = 0;
        {left_m, right_m, kv_m, held_m} = '0;
        vs_m = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sh_m[i] = 1'b0;
            cd_m[i] = 0;
            rel_m[i] = 1'b0;
            cnt_m[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit tk;
        bit same;
        if (reset_h) begin
            model_reset();
            return;
        end
        tk = vs_m && !VGA_VS;
        vs_m = VGA_VS;
        for (int i = 0; i < 2; i++) begin
            if (chk_coincide)
                check($sformatf("coincide%0d", i), 8'(shoot_last[i] & tk), 8'd0);
            if (sh_m[i]) begin
                sh_m[i] = 1'b0;
                cd_m[i] = cd_frames(i);
                cnt_m[i] = (cnt_m[i] + 1) % 256;
            end else if (cd_m[i] > 0) begin
                if (tk) begin
                    cd_m[i]--;
                    if (cd_m[i] == 0 && held_m) begin
                        if (i == 1) sh_m[i] = 1'b1;
                        else rel_m[i] = 1'b1;
                    end
                end
            end else if (rel_m[i]) begin
                if (!held_m) rel_m[i] = 1'b0;
            end else if (held_m) begin
                sh_m[i] = 1'b1;
            end
        end
        left_m  = (acc_m == 80) || (acc_m == 4);
        right_m = (acc_m == 79) || (acc_m == 7);
        held_m  = (acc_m == 44) || (acc_m == 26);
        kv_m    = acc_m != 0;
        hist.push_back(int'(keycode));
        void'(hist.pop_front());
        same = 1'b1;
        foreach (hist[k]) if (hist[k] != int'(keycode)) same = 1'b0;
        if (same) acc_m = int'(keycode);
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("shoot%0d", i), 8'(shoot[i]), 8'(sh_m[i]));
            check($sformatf("left%0d", i), 8'(left[i]), 8'(left_m));
            check($sformatf("right%0d", i), 8'(right[i]), 8'(right_m));
            check($sformatf("key_valid%0d", i), 8'(key_valid[i]), 8'(kv_m));
            check($sformatf("shot_count%0d", i), shot_count[i], 8'(cnt_m[i]));
            shoot_last[i] = shoot[i];
            if (shoot[i] === 1'b1) pulses[i]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic frame();
        VGA_VS = 1'b1;
        cycles(10);
        VGA_VS = 1'b0;
        cycles(2);
        VGA_VS = 1'b1;
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    int p0, p1;
    byte unsigned keys[8] = '{8'd0, 8'd44, 8'd26, 8'd80, 8'd4, 8'd79, 8'd7, 8'd0};

    initial begin
        reset_h = 1'b1;
        keycode = 8'd0;
        VGA_VS = 1'b1;
        pulses[0] = 0;
        pulses[1] = 0;
        model_reset();
        cycles(2);
        reset_h = 1'b0;
        check("rst_shot_count", shot_count[0], 8'd0);
        check("rst_key_valid", 8'(key_valid[0]), 8'd0);
        cycles(3);

        keycode = 8'd80;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) check("left_edge5", 8'(left[0]), 8'd0);
            if (k == 6) check("left_edge6", 8'(left[0]), 8'd1);
        end
        cycles(14);
        check("left_right", 8'(right[0]), 8'd0);
        check("left_kv", 8'(key_valid[0]), 8'd1);
        keycode = 8'd0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) check("left_fall5", 8'(left[0]), 8'd1);
            if (k == 6) check("left_fall6", 8'(left[0]), 8'd0);
        end
        cycles(4);

        keycode = 8'd44;
        cycles(3);
        keycode = 8'd0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("glitch_kv", 8'(key_valid[0]), 8'd0);
        end
        check("glitch_pulses", 8'(pulses[0] + pulses[1]), 8'd0);
        check("glitch_count", shot_count[0], 8'd0);

        p0 = pulses[0];
        p1 = pulses[1];
        keycode = 8'd44;
        chk_coincide = 1'b1;
        frames(10);
        check("auto_pulses10", 8'(pulses[1] - p1), 8'd6);
        frames(20);
        chk_coincide = 1'b0;
        check("hold_pulses", 8'(pulses[0] - p0), 8'd1);
        check("hold_count", shot_count[0], 8'd1);
        check("auto_pulses30", 8'(pulses[1] - p1), 8'd16);
        keycode = 8'd0;
        frames(10);
        keycode = 8'd44;
        frames(1);
        check("repress_count", shot_count[0], 8'd2);
        keycode = 8'd0;
        frames(12);

        p0 = pulses[0];
        VGA_VS = 1'b1;
        keycode = 8'd44;
        cycles(8);
        keycode = 8'd0;
        cycles(2);
        VGA_VS = 1'b0;
        cycles(2);
        VGA_VS = 1'b1;
        frames(2);
        keycode = 8'd44;
        frames(4);
        check("cd_no_shorten", 8'(pulses[0] - p0), 8'd1);
        frames(3);
        keycode = 8'd0;
        frames(12);

        keycode = 8'd44;
        cycles(10);
        reset_h = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("arst_shoot%0d", i), 8'(shoot[i]), 8'd0);
            check($sformatf("arst_count%0d", i), shot_count[i], 8'd0);
            check($sformatf("arst_kv%0d", i), 8'(key_valid[i]), 8'd0);
        end
        step();
        reset_h = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 6) check("rst_refire6", 8'(shoot[0]), 8'd0);
            if (k == 7) check("rst_refire7", 8'(shoot[0]), 8'd1);
            if (k == 8) check("rst_refire_count", shot_count[0], 8'd1);
        end

        for (int n = 0; n < 300; n++) begin
            keycode = (n % 5 == 4) ? 8'($urandom_range(0, 255)) : keys[$urandom_range(0, 7)];
            repeat ($urandom_range(1, 14)) begin
                VGA_VS = ($urandom_range(0, 3) != 0);
                step();
            end
            if ($urandom_range(0, 40) == 0) begin
                reset_h = 1'b1;
                step();
                reset_h = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
